// File: rtl/vector_sequencer.sv
// Issue-side sequencer for the 4-lane vector datapath: splits one instruction into 4-element
// chunks, drives register-file addresses, starts the PEs and commands the write-back.
module vector_sequencer (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [4:0] instr_vs1,
  input  logic [4:0] instr_vs2,
  input  logic [4:0] instr_vd,
  input  logic [1:0] instr_vsew,
  input  logic [5:0] instr_vl,
  input  logic       instr_widening,
  output logic [4:0] vs1_addr,
  output logic [4:0] vs2_addr,
  output logic [4:0] vd_addr,
  output logic [1:0] vsew,
  output logic       widening_op,
  output logic [1:0] elements_to_write,
  output logic       write,
  output logic       pe_start,
  input  logic       pe_done,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_e;

  state_e     state_q;
  logic [5:0] remaining_q;

  // Low address bits that must be zero for a register group of the given element width.
  function automatic logic [4:0] align_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    return 5'd0;
      2'd1:    return 5'd1;
      default: return 5'd3;
    endcase
  endfunction

  logic [1:0] acc_dst_sew;
  logic       illegal;
  logic [1:0] dst_sew;
  logic [4:0] src_step;
  logic [4:0] dst_step;
  logic [5:0] chunk;

  always_comb begin
    acc_dst_sew = instr_vsew + {1'b0, instr_widening};
    illegal     = (instr_vsew == 2'd3) || (instr_widening && (instr_vsew == 2'd2)) ||
                  (|(instr_vs1 & align_mask(instr_vsew))) ||
                  (|(instr_vs2 & align_mask(instr_vsew))) ||
                  (|(instr_vd & align_mask(acc_dst_sew)));
    dst_sew     = vsew + {1'b0, widening_op};
    src_step    = 5'd1 << vsew;
    dst_step    = 5'd1 << dst_sew;
    chunk       = (remaining_q < 6'd4) ? remaining_q : 6'd4;
  end

  assign instr_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q           <= StIdle;
      remaining_q       <= 6'd0;
      vs1_addr          <= 5'd0;
      vs2_addr          <= 5'd0;
      vd_addr           <= 5'd0;
      vsew              <= 2'd0;
      widening_op       <= 1'b0;
      elements_to_write <= 2'd0;
      write             <= 1'b0;
      pe_start          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      pe_start          <= 1'b0;
      write             <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      elements_to_write <= 2'd0;
      case (state_q)
        StIdle: begin
          if (instr_valid) begin
            vs1_addr    <= instr_vs1;
            vs2_addr    <= instr_vs2;
            vd_addr     <= instr_vd;
            vsew        <= instr_vsew;
            widening_op <= instr_widening;
            remaining_q <= instr_vl;
            if (illegal) begin
              err <= 1'b1;
            end else if (instr_vl == 6'd0) begin
              done <= 1'b1;
            end else begin
              state_q  <= StIssue;
              busy     <= 1'b1;
              pe_start <= 1'b1;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (pe_done) begin
            state_q           <= StWrite;
            write             <= 1'b1;
            elements_to_write <= (remaining_q < 6'd4) ? remaining_q[1:0] : 2'd0;
            // Retire together with the final write.
            done              <= (remaining_q <= 6'd4);
          end
        end
        StWrite: begin
          remaining_q <= remaining_q - chunk;
          vs1_addr    <= vs1_addr + src_step;
          vs2_addr    <= vs2_addr + src_step;
          vd_addr     <= vd_addr + dst_step;
          if (remaining_q > 6'd4) begin
            state_q  <= StIssue;
            pe_start <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: per-cycle expected outputs come from a chunk-level
// model of each accepted instruction; directed cases pin the model with literal values.
module tb_vector_sequencer;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [4:0] instr_vs1 = '0, instr_vs2 = '0, instr_vd = '0;
  logic [1:0] instr_vsew = '0;
  logic [5:0] instr_vl = '0;
  logic       instr_widening = 1'b0;
  logic [4:0] vs1_addr, vs2_addr, vd_addr;
  logic [1:0] vsew;
  logic       widening_op;
  logic [1:0] elements_to_write;
  logic       write, pe_start, busy, done, err;
  logic       pe_done;

  always #5 clk = ~clk;

  vector_sequencer dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_vs1        (instr_vs1),
    .instr_vs2        (instr_vs2),
    .instr_vd         (instr_vd),
    .instr_vsew       (instr_vsew),
    .instr_vl         (instr_vl),
    .instr_widening   (instr_widening),
    .vs1_addr         (vs1_addr),
    .vs2_addr         (vs2_addr),
    .vd_addr          (vd_addr),
    .vsew             (vsew),
    .widening_op      (widening_op),
    .elements_to_write(elements_to_write),
    .write            (write),
    .pe_start         (pe_start),
    .pe_done          (pe_done),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  typedef struct packed {
    logic       pe_start;
    logic       write;
    logic       done;
    logic       err;
    logic       busy;
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] ad;
    logic [1:0] ets;
  } rec_t;

  rec_t       exp_q[$];
  logic [1:0] exp_vsew = '0;
  logic       exp_wid = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         acc = 0;
  int         resp_k = 1;
  bit         resp_early = 1'b0;
  int         ps_cyc[$], ps_vs1[$], wr_cyc[$], wr_vd[$], wr_ets[$], done_cyc[$], err_cyc[$];

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: every cycle is checked against the model (idle when queue empty).
  always @(negedge clk) begin : compare
    rec_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("instr_ready", int'(instr_ready), int'(!e.busy));
    chk("busy", int'(busy), int'(e.busy));
    chk("pe_start", int'(pe_start), int'(e.pe_start));
    chk("write", int'(write), int'(e.write));
    chk("done", int'(done), int'(e.done));
    chk("err", int'(err), int'(e.err));
    chk("vsew", int'(vsew), int'(exp_vsew));
    chk("widening_op", int'(widening_op), int'(exp_wid));
    if (e.busy) begin
      chk("vs1_addr", int'(vs1_addr), int'(e.a1));
      chk("vs2_addr", int'(vs2_addr), int'(e.a2));
      chk("vd_addr", int'(vd_addr), int'(e.ad));
    end
    if (e.write) chk("elements_to_write", int'(elements_to_write), int'(e.ets));
    if (pe_start) begin ps_cyc.push_back(cyc); ps_vs1.push_back(int'(vs1_addr)); end
    if (write) begin
      wr_cyc.push_back(cyc); wr_vd.push_back(int'(vd_addr)); wr_ets.push_back(int'(elements_to_write));
    end
    if (done) done_cyc.push_back(cyc);
    if (err) err_cyc.push_back(cyc);
  end

  // PE responder: pe_done k cycles after pe_start; optional spurious pulse during ISSUE.
  initial begin
    pe_done = 1'b0;
    forever begin
      @(negedge clk);
      if (pe_start === 1'b1) begin
        if (resp_early) pe_done = 1'b1;
        @(posedge clk);
        #1 pe_done = 1'b0;
        for (int i = 1; i < resp_k; i++) begin
          @(posedge clk);
          #1;
        end
        pe_done = 1'b1;
        @(posedge clk);
        #1 pe_done = 1'b0;
      end
    end
  end

  // Model: expected per-cycle outputs following an accept.
  task automatic push_model(input int vs1, input int vs2, input int vd, input int sew, input int vl,
                            input int wid, input int k);
    int   s, ds, eff, rem, n, c;
    rec_t r;
    exp_vsew = 2'(sew);
    exp_wid  = wid[0];
    eff      = sew + wid;
    r        = '0;
    if (sew == 3 || eff > 2) begin
      r.err = 1'b1; exp_q.push_back(r); return;
    end
    s  = 1 << sew;
    ds = 1 << eff;
    if ((vs1 % s) != 0 || (vs2 % s) != 0 || (vd % ds) != 0) begin
      r.err = 1'b1; exp_q.push_back(r); return;
    end
    if (vl == 0) begin
      r.done = 1'b1; exp_q.push_back(r); return;
    end
    rem = vl;
    c   = 0;
    while (rem > 0) begin
      n = (rem < 4) ? rem : 4;
      r = '0;
      r.busy = 1'b1;
      r.a1 = 5'((vs1 + c * s) % 32);
      r.a2 = 5'((vs2 + c * s) % 32);
      r.ad = 5'((vd + c * ds) % 32);
      r.pe_start = 1'b1;
      exp_q.push_back(r);
      r.pe_start = 1'b0;
      for (int i = 0; i < k; i++) exp_q.push_back(r);
      r.write = 1'b1;
      r.ets = 2'((n == 4) ? 0 : n);
      r.done = (rem - n == 0);
      exp_q.push_back(r);
      rem -= n;
      c++;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      #1 guard++;
    end
    if (guard >= 2000) chk("drain timeout", guard, 0);
  endtask

  task automatic issue(input int vs1, input int vs2, input int vd, input int sew, input int vl,
                       input int wid, input int k, input bit early);
    wait_idle();
    resp_k         = k;
    resp_early     = early;
    instr_vs1      = 5'(vs1);
    instr_vs2      = 5'(vs2);
    instr_vd       = 5'(vd);
    instr_vsew     = 2'(sew);
    instr_vl       = 6'(vl);
    instr_widening = wid[0];
    instr_valid    = 1'b1;
    acc            = cyc;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    push_model(vs1, vs2, vd, sew, vl, wid, k);
  endtask

  task automatic clear_logs();
    ps_cyc.delete(); ps_vs1.delete(); wr_cyc.delete(); wr_vd.delete(); wr_ets.delete();
    done_cyc.delete(); err_cyc.delete();
  endtask

  initial begin
    #1 n_reset = 1'b0;
    #3;
    chk("reset instr_ready", int'(instr_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset vd_addr", int'(vd_addr), 0);
    @(posedge clk);
    @(posedge clk);
    #1 n_reset = 1'b1;

    // 8b, vl=10, k=1, pe_done held high through ISSUE.
    clear_logs();
    issue(4, 8, 12, 0, 10, 0, 1, 1'b1);
    wait_idle();
    chk("t8b pe_start count", ps_vs1.size(), 3);
    chk("t8b vs1[0]", qget(ps_vs1, 0), 4);
    chk("t8b vs1[1]", qget(ps_vs1, 1), 5);
    chk("t8b vs1[2]", qget(ps_vs1, 2), 6);
    chk("t8b vd[0]", qget(wr_vd, 0), 12);
    chk("t8b vd[2]", qget(wr_vd, 2), 14);
    chk("t8b ets[1]", qget(wr_ets, 1), 0);
    chk("t8b ets[2]", qget(wr_ets, 2), 2);
    chk("t8b first write cycle", qget(wr_cyc, 0), acc + 3);
    chk("t8b done cycle", qget(done_cyc, 0), acc + 9);

    // 32b, vl=5, k=3.
    clear_logs();
    issue(8, 16, 24, 2, 5, 0, 3, 1'b0);
    wait_idle();
    chk("t32b pe_start[1] cycle", qget(ps_cyc, 1), acc + 6);
    chk("t32b vd[0]", qget(wr_vd, 0), 24);
    chk("t32b vd[1]", qget(wr_vd, 1), 28);
    chk("t32b ets[1]", qget(wr_ets, 1), 1);
    chk("t32b done cycle", qget(done_cyc, 0), acc + 10);

    // Widening 16b -> 32b.
    clear_logs();
    issue(2, 4, 8, 1, 8, 1, 2, 1'b0);
    wait_idle();
    chk("twide vs1[1]", qget(ps_vs1, 1), 4);
    chk("twide vd[0]", qget(wr_vd, 0), 8);
    chk("twide vd[1]", qget(wr_vd, 1), 12);

    // Illegal instructions.
    clear_logs();
    issue(0, 0, 0, 3, 4, 0, 1, 1'b0);
    wait_idle();
    chk("ill sew3 err cycle", qget(err_cyc, 0), acc + 1);
    issue(0, 4, 6, 2, 4, 0, 1, 1'b0);
    wait_idle();
    chk("ill vd6 err cycle", qget(err_cyc, 1), acc + 1);
    issue(0, 0, 0, 2, 4, 1, 1, 1'b0);
    wait_idle();
    chk("ill wide32 err cycle", qget(err_cyc, 2), acc + 1);
    chk("ill pe_start count", ps_cyc.size(), 0);

    // vl = 0.
    clear_logs();
    issue(0, 0, 0, 0, 0, 0, 1, 1'b0);
    wait_idle();
    chk("vl0 done cycle", qget(done_cyc, 0), acc + 1);
    chk("vl0 write count", wr_cyc.size(), 0);

    // vl = 32 at 8b with address wrap.
    clear_logs();
    issue(28, 0, 16, 0, 32, 0, 1, 1'b0);
    wait_idle();
    chk("wrap pe_start count", ps_vs1.size(), 8);
    chk("wrap vs1[3]", qget(ps_vs1, 3), 31);
    chk("wrap vs1[4]", qget(ps_vs1, 4), 0);

    // Asynchronous reset during WAIT.
    issue(4, 6, 10, 1, 8, 0, 4, 1'b0);
    repeat (2) @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst instr_ready", int'(instr_ready), 1);
    chk("rst vs1_addr", int'(vs1_addr), 0);
    chk("rst vd_addr", int'(vd_addr), 0);
    chk("rst vsew", int'(vsew), 0);
    chk("rst write", int'(write) + int'(pe_start) + int'(done) + int'(err), 0);
    exp_q.delete();
    exp_vsew = '0;
    exp_wid  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 n_reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Randomized instructions.
    for (int t = 0; t < 40; t++) begin
      int sew, wid, s, ds, vs1, vs2, vd, vl, k;
      bit early;
      sew = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 2)) : 3;
      wid = ($urandom_range(0, 3) == 0) ? 1 : 0;
      s   = 1 << sew;
      ds  = 1 << ((sew + wid > 3) ? 3 : sew + wid);
      vs1 = int'($urandom_range(0, 31));
      vs2 = int'($urandom_range(0, 31));
      vd  = int'($urandom_range(0, 31));
      if ($urandom_range(0, 7) != 0) vs1 = vs1 & ~(s - 1);
      if ($urandom_range(0, 7) != 0) vs2 = vs2 & ~(s - 1);
      if ($urandom_range(0, 7) != 0) vd = vd & ~(ds - 1);
      vl    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 32));
      k     = int'($urandom_range(1, 4));
      early = ($urandom_range(0, 3) == 0);
      issue(vs1, vs2, vd, sew, vl, wid, k, early);
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
